// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - UART receiver (8N1, or 8E1 when RX_PARITY_EN is defined) with HEADER/CMD/ARG/CHK frame decoder
module uart_cmd_rx #(
   parameter int         CLKS_PER_BIT = 87,
   parameter logic [7:0] HEADER       = 8'hA5,
   parameter int         TIMEOUT_BITS = 20
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       uart_rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_busy,
   output logic       cmd_valid,
   output logic [7:0] cmd_code,
   output logic [7:0] cmd_arg,
   output logic       frame_err,
   output logic       chk_err
);

   localparam int HALF_BIT = CLKS_PER_BIT / 2;
   localparam int CNT_W    = $clog2(CLKS_PER_BIT + 1);
   localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int TO_W     = $clog2(TO_LIMIT + 1);

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
`ifdef RX_PARITY_EN
      , PARITY
`endif
   } byte_state_t;

   typedef enum logic [1:0] {P_HDR, P_CMD, P_ARG, P_CHK} parse_state_t;

   byte_state_t  state, state_d;
   parse_state_t pstate, pstate_d;

   logic             sync_1, sync_2, rx_prev;
   logic             rx_s, fall;
   logic [CNT_W-1:0] clk_cnt;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;
   logic             half_done, bit_done;
   logic             cnt_clr, shift_en, stop_smp;
   logic             par_ok;
   logic [TO_W-1:0]  to_cnt;
   logic             timeout;
   logic [7:0]       cmd_reg, arg_reg;
   logic             cmd_ld, arg_ld, chk_go, chk_match;

   assign rx_s      = sync_2;
   assign fall      = rx_prev & ~rx_s;
   assign half_done = (clk_cnt == CNT_W'(HALF_BIT - 1));
   assign bit_done  = (clk_cnt == CNT_W'(CLKS_PER_BIT - 1));
   assign rx_busy   = (state != IDLE);
   assign timeout   = (to_cnt == TO_W'(TO_LIMIT - 1));
   assign chk_match = (rx_data == (HEADER ^ cmd_reg ^ arg_reg));

   // Two-flop synchroniser for the asynchronous line, plus one delayed copy for edge detect
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_1  <= 1'b1;
         sync_2  <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync_1  <= uart_rx;
         sync_2  <= sync_1;
         rx_prev <= sync_2;
      end
   end

   // Byte FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_d;
   end

   // Byte FSM next state and per-cycle sampling controls
   always_comb begin
      state_d  = state;
      cnt_clr  = 1'b0;
      shift_en = 1'b0;
      stop_smp = 1'b0;
      case (state)
         IDLE: begin
            if (fall) begin
               state_d = START;
               cnt_clr = 1'b1;
            end
         end
         START: begin
            if (half_done) begin
               cnt_clr = 1'b1;
               state_d = rx_s ? IDLE : DATA;
            end
         end
         DATA: begin
            if (bit_done) begin
               cnt_clr  = 1'b1;
               shift_en = 1'b1;
               if (bit_cnt == 3'd7) begin
`ifdef RX_PARITY_EN
                  state_d = PARITY;
`else
                  state_d = STOP;
`endif
               end
            end
         end
`ifdef RX_PARITY_EN
         PARITY: begin
            if (bit_done) begin
               cnt_clr = 1'b1;
               state_d = STOP;
            end
         end
`endif
         STOP: begin
            if (bit_done) begin
               cnt_clr  = 1'b1;
               stop_smp = 1'b1;
               state_d  = rx_s ? IDLE : BREAK;
            end
         end
         BREAK: begin
            if (rx_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef RX_PARITY_EN
   logic par_bit;

   // Capture the parity bit at mid-bit; even parity over data plus parity must be zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                          par_bit <= 1'b0;
      else if (state == PARITY && bit_done) par_bit <= rx_s;
   end

   assign par_ok = ~(^shift_reg ^ par_bit);
`else
   assign par_ok = 1'b1;
`endif

   // Bit timing, deserialisation and the byte-level strobes, which land the cycle after the stop sample
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clk_cnt   <= '0;
         bit_cnt   <= '0;
         shift_reg <= '0;
         rx_data   <= '0;
         rx_valid  <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         if (cnt_clr || state == IDLE || state == BREAK) clk_cnt <= '0;
         else                                             clk_cnt <= clk_cnt + 1'b1;
         if (state == IDLE)  bit_cnt <= '0;
         else if (shift_en)  bit_cnt <= bit_cnt + 1'b1;
         if (shift_en) shift_reg <= {rx_s, shift_reg[7:1]};
         rx_valid  <= stop_smp & rx_s & par_ok;
         frame_err <= stop_smp & ~(rx_s & par_ok);
         if (stop_smp && rx_s && par_ok) rx_data <= shift_reg;
      end
   end

   // Parser state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) pstate <= P_HDR;
      else        pstate <= pstate_d;
   end

   // Parser next state: aborts on framing error or inter-byte timeout, otherwise advances per byte
   always_comb begin
      pstate_d = pstate;
      cmd_ld   = 1'b0;
      arg_ld   = 1'b0;
      chk_go   = 1'b0;
      if (frame_err) begin
         pstate_d = P_HDR;
      end else if (rx_valid) begin
         case (pstate)
            P_HDR: if (rx_data == HEADER) pstate_d = P_CMD;
            P_CMD: begin
               cmd_ld   = 1'b1;
               pstate_d = P_ARG;
            end
            P_ARG: begin
               arg_ld   = 1'b1;
               pstate_d = P_CHK;
            end
            P_CHK: begin
               chk_go   = 1'b1;
               pstate_d = P_HDR;
            end
            default: pstate_d = P_HDR;
         endcase
      end else if (timeout) begin
         pstate_d = P_HDR;
      end
   end

   // Inter-byte timeout counter, restarted by every received byte and idle while hunting for a header
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                           to_cnt <= '0;
      else if (pstate == P_HDR || rx_valid) to_cnt <= '0;
      else if (!timeout)                    to_cnt <= to_cnt + 1'b1;
   end

   // Frame fields and command outputs; outputs only change on a checksum match
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cmd_reg   <= '0;
         arg_reg   <= '0;
         cmd_code  <= '0;
         cmd_arg   <= '0;
         cmd_valid <= 1'b0;
         chk_err   <= 1'b0;
      end else begin
         if (cmd_ld) cmd_reg <= rx_data;
         if (arg_ld) arg_reg <= rx_data;
         cmd_valid <= chk_go & chk_match;
         chk_err   <= chk_go & ~chk_match;
         if (chk_go && chk_match) begin
            cmd_code <= cmd_reg;
            cmd_arg  <= arg_reg;
         end
      end
   end

endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - directed scoreboard testbench for uart_cmd_rx at CLKS_PER_BIT=8
module tb_uart_cmd_rx;

   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       uart_rx;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_busy;
   logic       cmd_valid;
   logic [7:0] cmd_code;
   logic [7:0] cmd_arg;
   logic       frame_err;
   logic       chk_err;

   int checks   = 0;
   int failures = 0;
   int n_rx     = 0;
   int n_cmd    = 0;
   int n_chk    = 0;
   int n_ferr   = 0;

   logic [7:0]  exp_rx_q[$];
   logic [15:0] exp_cmd_q[$];

   always #5 clk = ~clk;

   uart_cmd_rx #(
      .CLKS_PER_BIT(CPB),
      .HEADER      (8'hA5),
      .TIMEOUT_BITS(20)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .uart_rx  (uart_rx),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .rx_busy  (rx_busy),
      .cmd_valid(cmd_valid),
      .cmd_code (cmd_code),
      .cmd_arg  (cmd_arg),
      .frame_err(frame_err),
      .chk_err  (chk_err)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop, input logic expect_rx);
      if (expect_rx) exp_rx_q.push_back(b);
      uart_rx = 1'b0;
      tick(CPB);
      for (int i = 0; i < 8; i++) begin
         uart_rx = b[i];
         tick(CPB);
      end
      uart_rx = stop;
      tick(CPB);
   endtask

   task automatic send_frame(input logic [7:0] c, input logic [7:0] a, input logic [7:0] k,
                             input logic expect_cmd);
      if (expect_cmd) exp_cmd_q.push_back({c, a});
      send_byte(8'hA5, 1'b1, 1'b1);
      send_byte(c, 1'b1, 1'b1);
      send_byte(a, 1'b1, 1'b1);
      send_byte(k, 1'b1, 1'b1);
   endtask

   // Scoreboard: pop expectations as the DUT strobes, and check strobes are never simultaneous
   always @(negedge clk) begin : mon
      logic [15:0] e;
      if (rst_n === 1'b1) begin
         if (rx_valid) begin
            n_rx++;
            if (exp_rx_q.size() == 0) check("rx_unexpected", 32'(exp_rx_q.size()), 32'd1);
            else                      check("rx_data", 32'(rx_data), 32'(exp_rx_q.pop_front()));
         end
         if (cmd_valid) begin
            n_cmd++;
            if (exp_cmd_q.size() == 0) begin
               check("cmd_unexpected", 32'(exp_cmd_q.size()), 32'd1);
            end else begin
               e = exp_cmd_q.pop_front();
               check("cmd_code_arg", 32'({cmd_code, cmd_arg}), 32'(e));
            end
         end
         if (chk_err)   n_chk++;
         if (frame_err) n_ferr++;
         if (rx_valid || cmd_valid || chk_err || frame_err)
            check("strobe_exclusive",
                  32'(int'(rx_valid) + int'(cmd_valid) + int'(chk_err) + int'(frame_err)), 32'd1);
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog expired observed=running expected=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      int r0, c0, k0, f0, rise, fall, w;

      // Reset state
      rst_n   = 1'b0;
      uart_rx = 1'b1;
      tick(3);
      check("rst_rx_data",   32'(rx_data),   32'd0);
      check("rst_rx_valid",  32'(rx_valid),  32'd0);
      check("rst_rx_busy",   32'(rx_busy),   32'd0);
      check("rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("rst_cmd_code",  32'(cmd_code),  32'd0);
      check("rst_cmd_arg",   32'(cmd_arg),   32'd0);
      check("rst_frame_err", 32'(frame_err), 32'd0);
      check("rst_chk_err",   32'(chk_err),   32'd0);
      rst_n = 1'b1;
      tick(5);

      // Valid frame back to back
      r0 = n_rx; c0 = n_cmd; k0 = n_chk; f0 = n_ferr;
      send_frame(8'h10, 8'h64, 8'hD1, 1'b1);
      tick(10);
      check("f1_rx_count",  32'(n_rx - r0),   32'd4);
      check("f1_cmd_count", 32'(n_cmd - c0),  32'd1);
      check("f1_chk_count", 32'(n_chk - k0),  32'd0);
      check("f1_ferr",      32'(n_ferr - f0), 32'd0);
      check("f1_cmd_code",  32'(cmd_code),    32'h10);
      check("f1_cmd_arg",   32'(cmd_arg),     32'h64);

      // Checksum mismatch holds outputs; HEADER in CMD position is data
      c0 = n_cmd; k0 = n_chk;
      send_frame(8'h22, 8'h33, 8'h00, 1'b0);
      tick(10);
      check("bad_chk_count", 32'(n_chk - k0), 32'd1);
      check("bad_cmd_count", 32'(n_cmd - c0), 32'd0);
      check("bad_hold_code", 32'(cmd_code),   32'h10);
      check("bad_hold_arg",  32'(cmd_arg),    32'h64);
      c0 = n_cmd;
      send_frame(8'hA5, 8'h01, 8'h01, 1'b1);
      tick(10);
      check("hdr_as_data_count", 32'(n_cmd - c0), 32'd1);
      check("hdr_as_data_code",  32'(cmd_code),   32'hA5);

      // Three-cycle low glitch on idle line
      r0 = n_rx; rise = -1; fall = -1;
      uart_rx = 1'b0;
      for (int k = 1; k <= 15; k++) begin
         if (k == 4) uart_rx = 1'b1;
         tick(1);
         if (rx_busy && rise < 0) rise = k;
         if (!rx_busy && rise >= 0 && fall < 0) fall = k;
      end
      check("glitch_busy_rose", 32'(rise >= 0), 32'd1);
      check("glitch_busy_fall", 32'(fall >= 0 && (fall - rise) <= 5), 32'd1);
      tick(10);
      check("glitch_no_rx", 32'(n_rx - r0), 32'd0);
      send_byte(8'h55, 1'b1, 1'b1);
      tick(10);
      check("after_glitch_rx", 32'(n_rx - r0), 32'd1);
      check("after_glitch_data", 32'(rx_data), 32'h55);

      // Framing error mid-frame: line stuck low, parser aborted
      send_byte(8'hA5, 1'b1, 1'b1);
      f0 = n_ferr; c0 = n_cmd;
      send_byte(8'h3C, 1'b0, 1'b0);
      tick(30);
      check("brk_ferr_count", 32'(n_ferr - f0), 32'd1);
      check("brk_rx_data_held", 32'(rx_data), 32'hA5);
      check("brk_busy_held", 32'(rx_busy), 32'd1);
      uart_rx = 1'b1;
      w = 0;
      while (rx_busy && w < 8) begin
         tick(1);
         w++;
      end
      check("brk_busy_clears", 32'(rx_busy), 32'd0);
      tick(10);
      r0 = n_rx;
      send_byte(8'h10, 1'b1, 1'b1);
      send_byte(8'h64, 1'b1, 1'b1);
      send_byte(8'hD1, 1'b1, 1'b1);
      tick(10);
      check("brk_parser_hdr", 32'(n_cmd - c0), 32'd0);
      check("brk_rx_count",   32'(n_rx - r0),  32'd3);

      // Inter-byte timeout returns parser to header hunt
      c0 = n_cmd;
      send_byte(8'hA5, 1'b1, 1'b1);
      send_byte(8'h10, 1'b1, 1'b1);
      tick(20 * CPB);
      send_byte(8'h64, 1'b1, 1'b1);
      send_byte(8'hD1, 1'b1, 1'b1);
      tick(10);
      check("timeout_no_cmd", 32'(n_cmd - c0), 32'd0);
      send_frame(8'h10, 8'h64, 8'hD1, 1'b1);
      tick(10);
      check("timeout_recover", 32'(n_cmd - c0), 32'd1);

      // Reset during DATA of the second frame byte
      send_byte(8'hA5, 1'b1, 1'b1);
      uart_rx = 1'b0;
      tick(CPB + 20);
      check("mid_busy_before_rst", 32'(rx_busy), 32'd1);
      #3 rst_n = 1'b0;
      #1;
      check("mid_rst_rx_data",   32'(rx_data),   32'd0);
      check("mid_rst_rx_valid",  32'(rx_valid),  32'd0);
      check("mid_rst_rx_busy",   32'(rx_busy),   32'd0);
      check("mid_rst_cmd_valid", 32'(cmd_valid), 32'd0);
      check("mid_rst_cmd_code",  32'(cmd_code),  32'd0);
      check("mid_rst_cmd_arg",   32'(cmd_arg),   32'd0);
      check("mid_rst_frame_err", 32'(frame_err), 32'd0);
      check("mid_rst_chk_err",   32'(chk_err),   32'd0);
      uart_rx = 1'b1;
      tick(5);
      rst_n = 1'b1;
      tick(5);
      c0 = n_cmd;
      send_frame(8'h5A, 8'h0F, 8'hF0, 1'b1);
      tick(10);
      check("post_rst_cmd", 32'(n_cmd - c0), 32'd1);
      check("post_rst_code", 32'(cmd_code), 32'h5A);
      check("post_rst_arg",  32'(cmd_arg),  32'h0F);

      check("rx_queue_drained",  32'(exp_rx_q.size()),  32'd0);
      check("cmd_queue_drained", 32'(exp_cmd_q.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
